// File: rtl/gray_to_rgb565_ise_pkg.sv
// Shared definitions for the grayscale-to-RGB565 custom instruction:
// FSM state encoding and RGB565 field geometry.
package gray_to_rgb565_ise_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONV_LO = 2'd1,
    CONV_HI = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int GRAY_W = 8;
  localparam int R_W    = 5;
  localparam int G_W    = 6;
  localparam int B_W    = 5;
  localparam int PIX_W  = R_W + G_W + B_W;

endpackage

// File: rtl/gray_to_rgb565_pixel.sv
// Combinational conversion of one 8-bit gray sample into an RGB565 pixel.
// Each channel keeps the top bits of the gray value (truncation, no rounding).
module gray_to_rgb565_pixel
  import gray_to_rgb565_ise_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [PIX_W-1:0]  pixel
);

  assign pixel = {gray[GRAY_W-1 -: R_W], gray[GRAY_W-1 -: G_W], gray[GRAY_W-1 -: B_W]};

endmodule

// File: rtl/gray_to_rgb565_ise.sv
// Custom-instruction unit: converts a selected pair of packed gray pixels
// into two RGB565 pixels, one pixel per cycle through a shared converter.
module gray_to_rgb565_ise
  import gray_to_rgb565_ise_pkg::*;
#(
  parameter logic [7:0] customId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output state_t      dbgState
);

  // Handshake: an issue is taken on a clock edge with ciCke=1 only when
  // ciStart=1, ciN matches customId and the unit is IDLE; anything else is
  // dropped, never queued. ciDone is high exactly while in DONE, and ciResult
  // is zero whenever ciDone is low so it can be OR-combined on the CPU bus.

  state_t              state;
  logic [31:0]         a_q;
  logic                sel_q;
  logic                swap_q;
  logic [31:0]         res_q;
  logic [GRAY_W-1:0]   gray_in;
  logic [PIX_W-1:0]    pix_raw;
  logic [PIX_W-1:0]    pix_out;
  logic                accept;
  logic                unused_b;

  assign unused_b = ^ciValueB[31:2];
  assign accept   = ciStart && (ciN == customId) && (state == IDLE);

  // Lower pixel of the selected pair in CONV_LO, upper pixel otherwise.
  always_comb begin
    gray_in = '0;
    if (state == CONV_HI) begin
      gray_in = sel_q ? a_q[31:24] : a_q[15:8];
    end else begin
      gray_in = sel_q ? a_q[23:16] : a_q[7:0];
    end
  end

  gray_to_rgb565_pixel u_pixel (
    .gray  (gray_in),
    .pixel (pix_raw)
  );

  assign pix_out = swap_q ? {pix_raw[7:0], pix_raw[15:8]} : pix_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      a_q    <= '0;
      sel_q  <= 1'b0;
      swap_q <= 1'b0;
      res_q  <= '0;
    end else if (ciCke) begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q    <= ciValueA;
            sel_q  <= ciValueB[0];
            swap_q <= ciValueB[1];
            state  <= CONV_LO;
          end
        end
        CONV_LO: begin
          res_q[15:0] <= pix_out;
          state       <= CONV_HI;
        end
        CONV_HI: begin
          res_q[31:16] <= pix_out;
          state        <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ciDone   = (state == DONE);
  assign ciResult = ciDone ? res_q : 32'h0;
  assign dbgState = state;

endmodule

// File: tb/tb_gray_to_rgb565_ise.sv
// Bench for gray_to_rgb565_ise: vector table plus hand-built sequences for
// clock-enable stalls, reset aborts and filtered issues.
module tb_gray_to_rgb565_ise;
  import gray_to_rgb565_ise_pkg::*;

  localparam logic [7:0] ID = 8'h0B;

  logic        clock = 1'b0;
  logic        reset;
  logic        ciStart;
  logic        ciCke;
  logic [7:0]  ciN;
  logic [31:0] ciValueA;
  logic [31:0] ciValueB;
  logic        ciDone;
  logic [31:0] ciResult;
  state_t      dbgState;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  gray_to_rgb565_ise #(.customId(ID)) dut (
    .clock    (clock),
    .reset    (reset),
    .ciStart  (ciStart),
    .ciCke    (ciCke),
    .ciN      (ciN),
    .ciValueA (ciValueA),
    .ciValueB (ciValueB),
    .ciDone   (ciDone),
    .ciResult (ciResult),
    .dbgState (dbgState)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic        cke_at_edge = 1'b1;
  logic        prev_done = 1'b0;
  logic [31:0] last_res = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock) cke_at_edge <= ciCke;

  always @(negedge clock) begin
    if (ciDone) begin
      if (prev_done && !cke_at_edge) begin
        check("done_hold_result", ciResult, last_res);
      end else if (exp_q.size() == 0) begin
        check("unexpected_done", {31'b0, ciDone}, 32'h0);
      end else begin
        last_res = exp_q.pop_front();
        check("result", ciResult, last_res);
      end
    end else if (ciResult !== 32'h0) begin
      check("result_zero_when_idle", ciResult, 32'h0);
    end
    prev_done = ciDone;
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] model_px(input int g);
    int v;
    v = ((g / 8) * 2048) + ((g / 4) * 32) + (g / 8);
    return 16'(v);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] lo, hi;
    int base;
    base = b[0] ? 16 : 0;
    lo = model_px(int'((a >> base) & 32'hFF));
    hi = model_px(int'((a >> (base + 8)) & 32'hFF));
    if (b[1]) begin
      lo = {lo[7:0], lo[15:8]};
      hi = {hi[7:0], hi[15:8]};
    end
    return {hi, lo};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int lat;
    lat = 0;
    @(negedge clock);
    ciStart = 1'b1; ciN = ID; ciValueA = a; ciValueB = b;
    exp_q.push_back(exp);
    @(posedge clock);
    #1;
    ciStart = 1'b0; ciValueA = $urandom; ciValueB = $urandom;
    do begin
      @(negedge clock);
      lat++;
    end while (!ciDone && lat < 20);
    check({name, "_latency"}, lat, 3);
    @(negedge clock);
    check({name, "_pulse_width"}, {31'b0, ciDone}, 32'h0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hFF80_12FF, 32'h0000_0000, 32'h1082_FFFF};
    vecs[1] = '{32'hFF80_12FF, 32'h0000_0001, 32'hFFFF_8410};
    vecs[2] = '{32'hFF80_12FF, 32'h0000_0003, 32'hFFFF_1084};
    vecs[3] = '{32'hFF80_12FF, 32'h0000_0002, 32'h8210_FFFF};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[5] = '{32'h0000_0000, 32'h0000_0002, 32'h0000_0000};
    vecs[6] = '{32'h0408_F807, 32'h0000_0000, 32'hFFDF_0020};
    vecs[7] = '{32'h0408_F807, 32'h0000_0001, 32'h0020_0841};
    vecs[8] = '{32'hFF80_12FF, 32'hFFFF_FFFC, 32'h1082_FFFF};

    reset = 1'b1; ciStart = 1'b0; ciCke = 1'b1; ciN = 8'h00;
    ciValueA = 32'h0; ciValueB = 32'h0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_state", 32'(dbgState), 32'(IDLE));
    check("reset_done", {31'b0, ciDone}, 32'h0);
    check("reset_result", ciResult, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 8; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = 32'($urandom_range(0, 3));
      run_op(a, b, model(a, b), $sformatf("rand%0d", i));
    end

    // Non-matching instruction number is ignored.
    @(negedge clock);
    ciStart = 1'b1; ciN = 8'h0C; ciValueA = 32'hFF80_12FF; ciValueB = 32'h0;
    @(posedge clock);
    #1 ciStart = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("wrong_n_done", {31'b0, ciDone}, 32'h0);
      check("wrong_n_state", 32'(dbgState), 32'(IDLE));
    end

    // Clock-enable stall in CONV_HI with operand change and a repeated issue.
    @(negedge clock);
    ciStart = 1'b1; ciN = ID; ciValueA = 32'hFF80_12FF; ciValueB = 32'h0;
    exp_q.push_back(32'h1082_FFFF);
    @(posedge clock);
    #1 ciStart = 1'b0;
    @(negedge clock);
    check("stall_conv_lo", 32'(dbgState), 32'(CONV_LO));
    @(negedge clock);
    check("stall_conv_hi", 32'(dbgState), 32'(CONV_HI));
    ciCke = 1'b0; ciValueA = 32'h0; ciStart = 1'b1; ciN = ID;
    @(negedge clock);
    check("stall_hold1", 32'(dbgState), 32'(CONV_HI));
    @(negedge clock);
    check("stall_hold2", 32'(dbgState), 32'(CONV_HI));
    ciCke = 1'b1;
    @(negedge clock);
    check("stall_done", {31'b0, ciDone}, 32'h1);
    ciStart = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("stall_no_second_done", {31'b0, ciDone}, 32'h0);
    end

    // Clock-enable low while in DONE keeps the result on the bus.
    @(negedge clock);
    ciStart = 1'b1; ciN = ID; ciValueA = 32'h0408_F807; ciValueB = 32'h1;
    exp_q.push_back(32'h0020_0841);
    @(posedge clock);
    #1 ciStart = 1'b0;
    repeat (3) @(negedge clock);
    check("hold_done_enter", {31'b0, ciDone}, 32'h1);
    ciCke = 1'b0;
    repeat (2) begin
      @(negedge clock);
      check("hold_done_stays", {31'b0, ciDone}, 32'h1);
    end
    ciCke = 1'b1;
    @(negedge clock);
    check("hold_done_release", {31'b0, ciDone}, 32'h0);

    // Reset in CONV_LO (with ciCke low) aborts without a completion pulse.
    @(negedge clock);
    ciStart = 1'b1; ciN = ID; ciValueA = 32'hFF80_12FF; ciValueB = 32'h0;
    @(posedge clock);
    #1 ciStart = 1'b0;
    @(negedge clock);
    check("abort_conv_lo", 32'(dbgState), 32'(CONV_LO));
    reset = 1'b1; ciCke = 1'b0;
    @(negedge clock);
    check("abort_idle", 32'(dbgState), 32'(IDLE));
    reset = 1'b0; ciCke = 1'b1;
    repeat (5) begin
      @(negedge clock);
      check("abort_no_done", {31'b0, ciDone}, 32'h0);
    end
    run_op(32'hFF80_12FF, 32'h1, 32'hFFFF_8410, "after_abort");

    // Issue coincident with reset is dropped.
    @(negedge clock);
    reset = 1'b1; ciStart = 1'b1; ciN = ID;
    @(negedge clock);
    check("issue_in_reset_state", 32'(dbgState), 32'(IDLE));
    reset = 1'b0; ciStart = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("issue_in_reset_no_done", {31'b0, ciDone}, 32'h0);
    end

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_to_rgb565_ise.md
GRAY_TO_RGB565_ISE -- requirements
Module: gray_to_rgb565_ise

Interface
REQ-001 The block SHALL have parameter customId, default 8'd0, giving the custom-instruction number the block responds to.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port ciStart, input, 1 bit, instruction-issue strobe from the CPU.
REQ-005 The block SHALL have port ciCke, input, 1 bit, clock enable; when 0 all internal state holds.
REQ-006 The block SHALL have port ciN, input, 8 bits, custom-instruction number of the current issue.
REQ-007 The block SHALL have port ciValueA, input, 32 bits, four packed 8-bit grayscale pixels: P0=[7:0], P1=[15:8], P2=[23:16], P3=[31:24].
REQ-008 The block SHALL have port ciValueB, input, 32 bits, control: bit0 = pair select (0: P0/P1, 1: P2/P3); bit1 = byte swap; bits[31:2] ignored.
REQ-009 The block SHALL have port ciDone, output, 1 bit, one-cycle completion pulse.
REQ-010 The block SHALL have port ciResult, output, 32 bits, two packed RGB565 pixels, valid only while ciDone=1.

Function
REQ-011 The block SHALL accept an issue only when ciStart=1, ciCke=1, ciN==customId and the state is IDLE; all other issues SHALL be ignored with no response.
REQ-012 On acceptance the block SHALL latch ciValueA and ciValueB[1:0]; later changes on those inputs SHALL have no effect on the operation.
REQ-013 The state machine SHALL have states IDLE, CONV_LO, CONV_HI, DONE: IDLE->CONV_LO on acceptance; CONV_LO->CONV_HI; CONV_HI->DONE; DONE->IDLE; each transition only when ciCke=1.
REQ-014 In CONV_LO the block SHALL convert the lower pixel of the selected pair (P0 or P2) into result bits [15:0]; in CONV_HI the upper pixel (P1 or P3) into result bits [31:16].
REQ-015 The conversion of gray g SHALL be R5=g[7:3], G6=g[7:2], B5=g[7:3], pixel = {R5,G6,B5}, truncating with no rounding.
REQ-016 When the latched swap bit is 1, each 16-bit pixel SHALL have its two bytes exchanged before output.
REQ-017 ciDone SHALL be 1 exactly while the state is DONE and 0 otherwise; with ciCke held at 1, ciDone asserts 3 cycles after the accepting edge.
REQ-018 ciResult SHALL be the converted pair while ciDone=1 and 32'h0 at all other times, because the result bus is OR-combined.
REQ-019 ciStart asserted in CONV_LO, CONV_HI or DONE SHALL be ignored and SHALL NOT be queued; the next issue is accepted only from IDLE.
REQ-020 When ciCke=0 in any state, the state, the latched operands and the partial result SHALL hold.
REQ-021 If the state is DONE while ciCke=0, ciDone and ciResult SHALL remain asserted until the cycle in which ciCke=1.

Reset
REQ-022 While reset=1 at a clock edge, the state SHALL become IDLE and the latched operands and partial result SHALL become 0, regardless of ciCke.
REQ-023 Consequently ciDone=0 and ciResult=0 SHALL hold from the first edge at which reset=1.
REQ-024 A reset during an operation SHALL abort it with no ciDone pulse.
REQ-025 An issue coincident with reset SHALL be ignored.

Structure
REQ-026 A shared package SHALL hold the state encoding (IDLE, CONV_LO, CONV_HI, DONE) and the RGB565 field widths (5/6/5).
REQ-027 The per-pixel conversion SHALL be a combinational sub-module gray_to_rgb565_pixel (8-bit in, 16-bit out), instantiated once and time-shared across CONV_LO and CONV_HI.

Verification
REQ-028 Issue with customId=0x0B, ciN=0x0B, A=0xFF80_12FF, B=0 and ciCke=1 -> ciDone pulses 3 cycles later for exactly 1 cycle with ciResult=0x1082_FFFF.
REQ-029 Same A with B=1, then with B=3 -> ciResult=0xFFFF_8410, then ciResult=0xFFFF_1084.
REQ-030 Issue with ciN=0x0C while customId=0x0B -> ciDone and ciResult stay 0 for 10 cycles.
REQ-031 Hold ciCke=0 for 2 cycles during CONV_HI, while A changes and a second ciStart is asserted -> ciDone is delayed by 2 cycles, the result is for the original A, and no second ciDone occurs.
REQ-032 Assert reset in CONV_LO -> the next cycle is IDLE, no ciDone pulse, and a new issue afterwards completes normally.
REQ-033 Issue with A=0 -> ciResult=0x0000_0000 with ciDone=1, distinguishable only by ciDone.
